// File: rtl/wb_mux_timeout.sv
// Wishbone 1-to-N address-decoding multiplexer with a response watchdog.
// A single transaction is outstanding at a time; unmapped addresses get a
// one-cycle error and a slave that stays silent for TIMEOUT cycles is cut off.
module wb_mux_timeout #(
  parameter int unsigned                   NUM_SLAVES = 8,
  parameter int unsigned                   AW         = 32,
  parameter int unsigned                   DW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0]      MATCH_ADDR = {NUM_SLAVES{{AW{1'b0}}}},
  parameter logic [NUM_SLAVES*AW-1:0]      MATCH_MASK = {NUM_SLAVES{{AW{1'b0}}}},
  parameter int unsigned                   TIMEOUT    = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  // master request
  input  logic [AW-1:0]              wbm_adr_i,
  input  logic [DW-1:0]              wbm_dat_i,
  input  logic [DW/8-1:0]            wbm_sel_i,
  input  logic                       wbm_we_i,
  input  logic                       wbm_cyc_i,
  input  logic                       wbm_stb_i,
  input  logic [2:0]                 wbm_cti_i,
  input  logic [1:0]                 wbm_bte_i,
  // master response
  output logic [DW-1:0]              wbm_dat_o,
  output logic                       wbm_ack_o,
  output logic                       wbm_err_o,
  output logic                       wbm_rty_o,
  // slave requests, slave 0 in the LSB slice
  output logic [NUM_SLAVES*AW-1:0]   wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]   wbs_dat_o,
  output logic [NUM_SLAVES*DW/8-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]      wbs_we_o,
  output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]      wbs_stb_o,
  output logic [NUM_SLAVES*3-1:0]    wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]    wbs_bte_o,
  // slave responses
  input  logic [NUM_SLAVES*DW-1:0]   wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]      wbs_err_i,
  input  logic [NUM_SLAVES-1:0]      wbs_rty_i,
  // diagnostics
  output logic                       timeout_o,
  output logic [AW-1:0]              fault_adr_o
);

  localparam int unsigned SW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // TIMEOUT == 0 disables the watchdog; keep a 1-bit counter so widths stay legal.
  localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DECERR,
    TOUT
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   fault_adr_q, fault_adr_d;

  logic            hit;
  logic [SW-1:0]   hit_idx;
  logic [DW-1:0]   slv_dat;
  logic            slv_ack, slv_err, slv_rty;

  // Request fields are broadcast to every slave; only cyc/stb select one.
  assign wbs_adr_o   = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o   = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o   = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o    = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o   = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o   = {NUM_SLAVES{wbm_bte_i}};
  assign fault_adr_o = fault_adr_q;

  // Address decode: the lowest-numbered matching slave wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((wbm_adr_i & MATCH_MASK[i*AW +: AW]) ==
                   (MATCH_ADDR[i*AW +: AW] & MATCH_MASK[i*AW +: AW]))) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  // Response mux from the currently selected slave.
  always_comb begin
    slv_dat = '0;
    slv_ack = 1'b0;
    slv_err = 1'b0;
    slv_rty = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SW'(i)) begin
        slv_dat = wbs_dat_i[i*DW +: DW];
        slv_ack = wbs_ack_i[i];
        slv_err = wbs_err_i[i];
        slv_rty = wbs_rty_i[i];
      end
    end
  end

  // Next-state, watchdog and output logic.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    count_d     = count_q;
    fault_adr_d = fault_adr_q;
    wbs_cyc_o   = '0;
    wbs_stb_o   = '0;
    wbm_dat_o   = '0;
    wbm_ack_o   = 1'b0;
    wbm_err_o   = 1'b0;
    wbm_rty_o   = 1'b0;
    timeout_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (hit) begin
            sel_d   = hit_idx;
            count_d = '0;
            state_d = ACTIVE;
          end else begin
            fault_adr_d = wbm_adr_i;
            state_d     = DECERR;
          end
        end
      end
      ACTIVE: begin
        wbs_cyc_o[sel_q] = wbm_cyc_i;
        wbs_stb_o[sel_q] = wbm_stb_i;
        wbm_dat_o        = slv_dat;
        wbm_ack_o        = slv_ack;
        wbm_err_o        = slv_err;
        wbm_rty_o        = slv_rty;
        // A response or abort takes priority over the watchdog on the same cycle.
        if (!wbm_cyc_i || slv_ack || slv_err || slv_rty) begin
          state_d = IDLE;
        end else if (TIMEOUT != 0) begin
          if (count_q == CW'(TLIM)) begin
            state_d = TOUT;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      DECERR: begin
        wbm_err_o = 1'b1;
        state_d   = IDLE;
      end
      TOUT: begin
        wbm_err_o   = 1'b1;
        timeout_o   = 1'b1;
        fault_adr_d = wbm_adr_i;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences the bus in the same cycle it is asserted.
    if (wb_rst_i) begin
      wbs_cyc_o = '0;
      wbs_stb_o = '0;
      wbm_ack_o = 1'b0;
      wbm_err_o = 1'b0;
      wbm_rty_o = 1'b0;
      timeout_o = 1'b0;
    end
  end

  // State, selection, watchdog counter and fault-address registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      count_q     <= '0;
      fault_adr_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      count_q     <= count_d;
      fault_adr_q <= fault_adr_d;
    end
  end

endmodule

// File: tb/tb_wb_mux_timeout.sv
// Self-checking bench for wb_mux_timeout: 8 slaves, TIMEOUT = 4.
// Slaves 0..6 decode i*0x1000 (64-byte windows); slave 7 decodes 0x2000/4KB,
// overlapping slave 2 so the lowest-index priority is exercised.
module tb_wb_mux_timeout;

  localparam int unsigned NS = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [NS*AW-1:0] ADDRS = {32'h0000_2000, 32'h0000_6000, 32'h0000_5000,
                                         32'h0000_4000, 32'h0000_3000, 32'h0000_2000,
                                         32'h0000_1000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASKS = {32'hFFFF_F000, {7{32'hFFFF_FFC0}}};

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     m_adr;
  logic [DW-1:0]     m_dat;
  logic [DW/8-1:0]   m_sel;
  logic              m_we, m_cyc, m_stb;
  logic [2:0]        m_cti;
  logic [1:0]        m_bte;
  logic [DW-1:0]     wbm_dat_o;
  logic              wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [NS*AW-1:0]  wbs_adr_o;
  logic [NS*DW-1:0]  wbs_dat_o;
  logic [NS*DW/8-1:0] wbs_sel_o;
  logic [NS-1:0]     wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [NS*3-1:0]   wbs_cti_o;
  logic [NS*2-1:0]   wbs_bte_o;
  logic [NS*DW-1:0]  s_dat;
  logic [NS-1:0]     s_ack, s_err, s_rty;
  logic              timeout_o;
  logic [AW-1:0]     fault_adr_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]    rsp;   // {ack, err, rty}
    logic [DW-1:0] dat;
    logic          tout;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  wb_mux_timeout #(
    .NUM_SLAVES (NS),
    .AW         (AW),
    .DW         (DW),
    .MATCH_ADDR (ADDRS),
    .MATCH_MASK (MASKS),
    .TIMEOUT    (4)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbm_adr_i   (m_adr),
    .wbm_dat_i   (m_dat),
    .wbm_sel_i   (m_sel),
    .wbm_we_i    (m_we),
    .wbm_cyc_i   (m_cyc),
    .wbm_stb_i   (m_stb),
    .wbm_cti_i   (m_cti),
    .wbm_bte_i   (m_bte),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_o   (wbm_ack_o),
    .wbm_err_o   (wbm_err_o),
    .wbm_rty_o   (wbm_rty_o),
    .wbs_adr_o   (wbs_adr_o),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_sel_o   (wbs_sel_o),
    .wbs_we_o    (wbs_we_o),
    .wbs_cyc_o   (wbs_cyc_o),
    .wbs_stb_o   (wbs_stb_o),
    .wbs_cti_o   (wbs_cti_o),
    .wbs_bte_o   (wbs_bte_o),
    .wbs_dat_i   (s_dat),
    .wbs_ack_i   (s_ack),
    .wbs_err_i   (s_err),
    .wbs_rty_i   (s_rty),
    .timeout_o   (timeout_o),
    .fault_adr_o (fault_adr_o)
  );

  // Response scoreboard: every master response pops one expected entry.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got ack/err/rty=%b%b%b tout=%b, required no response",
                 wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o);
      end else begin
        e = exp_q.pop_front();
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== e.rsp || timeout_o !== e.tout ||
            (e.rsp[2] && wbm_dat_o !== e.dat)) begin
          errors++;
          $display("FAIL rsp_scoreboard: got ack/err/rty=%b%b%b tout=%b dat=%h, required %b tout=%b dat=%h",
                   wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o, wbm_dat_o, e.rsp, e.tout, e.dat);
        end
      end
    end else if (timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_timeout: got timeout_o=%b, required 0", timeout_o);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic master(input logic [AW-1:0] a, input logic c);
    m_adr = a;
    m_cyc = c;
    m_stb = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    master(32'h0, 1'b0);
    m_dat = 32'h5555_AAAA; m_sel = 4'hF; m_we = 1'b0; m_cti = 3'd0; m_bte = 2'd0;
    s_dat = '0; s_ack = '0; s_err = '0; s_rty = '0;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++;
    if (wbs_cyc_o !== 8'h00 || wbs_stb_o !== 8'h00 || wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0 ||
        wbm_rty_o !== 1'b0 || timeout_o !== 1'b0 || fault_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got cyc=%h stb=%h a/e/r=%b%b%b tout=%b fadr=%h, required all 0",
               wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o, fault_adr_o);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_read();
    next_cycle();                         // cycle 0
    master(32'h0000_1004, 1'b1);
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h00) begin
      errors++; $display("FAIL rd_c0_stb: got %h, required 00", wbs_stb_o);
    end
    exp_q.push_back('{rsp: 3'b100, dat: 32'hA5A5_1111, tout: 1'b0});
    for (int c = 1; c <= 2; c++) begin    // cycles 1..2
      next_cycle();
      @(negedge clk);
      checks++;
      if (wbs_stb_o !== 8'h02 || wbs_cyc_o !== 8'h02) begin
        errors++; $display("FAIL rd_wait_stb: cycle %0d got stb=%h cyc=%h, required 02", c, wbs_stb_o, wbs_cyc_o);
      end
    end
    next_cycle();                         // cycle 3: slave 1 acks, slave 0 noise ignored
    s_dat[32 +: 32] = 32'hA5A5_1111;
    s_dat[0 +: 32]  = 32'hDEAD_BEEF;
    s_ack = 8'h03;
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h02 || wbs_adr_o[5*32 +: 32] !== 32'h0000_1004) begin
      errors++; $display("FAIL rd_ack_cycle: got stb=%h adr5=%h, required 02 / 00001004", wbs_stb_o, wbs_adr_o[5*32 +: 32]);
    end
    next_cycle();                         // cycle 4
    master(32'h0, 1'b0);
    s_ack = '0;
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h00) begin
      errors++; $display("FAIL rd_done_stb: got %h, required 00", wbs_stb_o);
    end
  endtask

  task automatic test_decerr();
    next_cycle();                         // cycle 0
    master(32'h0000_9000, 1'b1);
    exp_q.push_back('{rsp: 3'b010, dat: 32'h0, tout: 1'b0});
    next_cycle();                         // cycle 1: error
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h00 || wbs_cyc_o !== 8'h00 || fault_adr_o !== 32'h0000_9000) begin
      errors++; $display("FAIL decerr: got stb=%h cyc=%h fadr=%h, required 00/00/00009000", wbs_stb_o, wbs_cyc_o, fault_adr_o);
    end
    next_cycle();                         // cycle 2
    master(32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (wbm_err_o !== 1'b0) begin
      errors++; $display("FAIL decerr_one_cycle: got err=%b, required 0", wbm_err_o);
    end
  endtask

  task automatic test_timeout();
    next_cycle();                         // cycle 0
    master(32'h0000_3000, 1'b1);
    exp_q.push_back('{rsp: 3'b010, dat: 32'h0, tout: 1'b1});
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (wbs_stb_o !== 8'h08) begin
        errors++; $display("FAIL tout_wait_stb: cycle %0d got %h, required 08", c, wbs_stb_o);
      end
    end
    next_cycle();                         // cycle 5: watchdog fires
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h00 || wbs_cyc_o !== 8'h00 || timeout_o !== 1'b1) begin
      errors++; $display("FAIL tout_fire: got stb=%h cyc=%h tout=%b, required 00/00/1", wbs_stb_o, wbs_cyc_o, timeout_o);
    end
    next_cycle();                         // cycle 6
    master(32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (fault_adr_o !== 32'h0000_3000 || wbs_stb_o !== 8'h00) begin
      errors++; $display("FAIL tout_fadr: got fadr=%h stb=%h, required 00003000/00", fault_adr_o, wbs_stb_o);
    end
  endtask

  task automatic test_late_ack();
    next_cycle();                         // cycle 0
    master(32'h0000_4008, 1'b1);
    repeat (3) next_cycle();              // cycles 1..3
    next_cycle();                         // cycle 4: count == TIMEOUT-1
    s_dat[4*32 +: 32] = 32'hC0DE_4444;
    s_ack[4] = 1'b1;
    exp_q.push_back('{rsp: 3'b100, dat: 32'hC0DE_4444, tout: 1'b0});
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h10) begin
      errors++; $display("FAIL late_ack_stb: got %h, required 10", wbs_stb_o);
    end
    next_cycle();                         // cycle 5
    master(32'h0, 1'b0);
    s_ack = '0;
    @(negedge clk);
    checks++;
    if (wbm_err_o !== 1'b0 || fault_adr_o !== 32'h0000_3000) begin
      errors++; $display("FAIL late_ack_no_tout: got err=%b fadr=%h, required 0/00003000", wbm_err_o, fault_adr_o);
    end
  endtask

  task automatic test_abort();
    next_cycle();                         // cycle 0: overlaps slaves 2 and 7
    master(32'h0000_2010, 1'b1);
    next_cycle();                         // cycle 1
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h04) begin
      errors++; $display("FAIL abort_prio_stb: got %h, required 04", wbs_stb_o);
    end
    next_cycle();                         // cycle 2: master aborts
    master(32'h0000_2010, 1'b0);
    @(negedge clk);
    checks++;
    if (wbs_cyc_o !== 8'h00) begin
      errors++; $display("FAIL abort_cyc_drop: got %h, required 00", wbs_cyc_o);
    end
    next_cycle();                         // cycle 3: new request, slave 7 only
    master(32'h0000_2100, 1'b1);
    @(negedge clk);
    checks++;
    if (wbs_cyc_o !== 8'h00) begin
      errors++; $display("FAIL abort_new_c0: got %h, required 00", wbs_cyc_o);
    end
    next_cycle();                         // cycle 4
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h80) begin
      errors++; $display("FAIL abort_new_stb: got %h, required 80", wbs_stb_o);
    end
    next_cycle();                         // cycle 5: slave 7 err, slave 2 ack ignored
    s_err[7] = 1'b1;
    s_ack[2] = 1'b1;
    exp_q.push_back('{rsp: 3'b010, dat: 32'h0, tout: 1'b0});
    next_cycle();                         // cycle 6
    master(32'h0, 1'b0);
    s_err = '0; s_ack = '0;
    @(negedge clk);
    checks++;
    if (wbs_cyc_o !== 8'h00) begin
      errors++; $display("FAIL abort_end_cyc: got %h, required 00", wbs_cyc_o);
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();                         // cycle 0: burst beat to slave 0
    master(32'h0000_0000, 1'b1);
    m_cti = 3'b010; m_bte = 2'b01;
    next_cycle();                         // cycle 1: zero-wait ack
    s_dat[0 +: 32] = 32'h1234_0000;
    s_ack[0] = 1'b1;
    exp_q.push_back('{rsp: 3'b100, dat: 32'h1234_0000, tout: 1'b0});
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h01 || wbs_cti_o[3*3 +: 3] !== 3'b010 || wbs_bte_o[6*2 +: 2] !== 2'b01) begin
      errors++; $display("FAIL b2b_first: got stb=%h cti3=%b bte6=%b, required 01/010/01",
                         wbs_stb_o, wbs_cti_o[3*3 +: 3], wbs_bte_o[6*2 +: 2]);
    end
    next_cycle();                         // cycle 2: IDLE re-decodes next address
    master(32'h0000_5000, 1'b1);
    s_ack = '0;
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h00) begin
      errors++; $display("FAIL b2b_idle: got %h, required 00", wbs_stb_o);
    end
    next_cycle();                         // cycle 3: slave 5 retries
    s_rty[5] = 1'b1;
    exp_q.push_back('{rsp: 3'b001, dat: 32'h0, tout: 1'b0});
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h20) begin
      errors++; $display("FAIL b2b_second: got %h, required 20", wbs_stb_o);
    end
    next_cycle();                         // cycle 4
    master(32'h0, 1'b0);
    s_rty = '0; m_cti = 3'd0; m_bte = 2'd0;
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h00) begin
      errors++; $display("FAIL b2b_end: got %h, required 00", wbs_stb_o);
    end
  endtask

  task automatic test_reset_active();
    next_cycle();                         // cycle 0
    master(32'h0000_6000, 1'b1);
    next_cycle();                         // cycle 1
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h40) begin
      errors++; $display("FAIL rst_act_stb: got %h, required 40", wbs_stb_o);
    end
    next_cycle();                         // cycle 2: reset while slave acks
    rst = 1'b1;
    s_ack[6] = 1'b1;
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h00 || wbs_cyc_o !== 8'h00 || wbm_ack_o !== 1'b0) begin
      errors++; $display("FAIL rst_act_during: got stb=%h cyc=%h ack=%b, required 00/00/0", wbs_stb_o, wbs_cyc_o, wbm_ack_o);
    end
    next_cycle();                         // cycle 3
    rst = 1'b0;
    s_ack = '0;
    master(32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h00 || fault_adr_o !== 32'h0) begin
      errors++; $display("FAIL rst_act_after: got stb=%h fadr=%h, required 00/00000000", wbs_stb_o, fault_adr_o);
    end
    next_cycle();                         // cycle 4: fresh access from IDLE
    master(32'h0000_1000, 1'b1);
    next_cycle();                         // cycle 5
    s_dat[32 +: 32] = 32'h0BAD_F00D;
    s_ack[1] = 1'b1;
    exp_q.push_back('{rsp: 3'b100, dat: 32'h0BAD_F00D, tout: 1'b0});
    @(negedge clk);
    checks++;
    if (wbs_stb_o !== 8'h02) begin
      errors++; $display("FAIL rst_act_idle: got %h, required 02", wbs_stb_o);
    end
    next_cycle();
    master(32'h0, 1'b0);
    s_ack = '0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_decerr();
    test_timeout();
    test_late_ack();
    test_abort();
    test_back_to_back();
    test_reset_active();
    repeat (2) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_rsp: got %0d unconsumed expected responses, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
